// File: rtl/proj_fm_reader.sv
// FM read-window serializer: buffers incoming windows in a small FIFO and emits them byte by byte.
// Optional drop counter output enabled by defining PROJ_FM_READER_DROP_CNT_EN.
package proj_pkg;
    localparam int FM_GENOME_BTYE                = 8;
    localparam int FM_EXTENDER_BYTES_READ_COUNT  = 4;
    localparam int FM_RAMS_COUNT                 = 2;
    localparam int FM_ENTRIES_COUNT              = 2;
    localparam int FM_OFFSET_COUNT               = 4;
endpackage

module proj_fm_reader #(
    parameter int DATA_BITS  = proj_pkg::FM_GENOME_BTYE,
    parameter int READ_BYTES = proj_pkg::FM_EXTENDER_BYTES_READ_COUNT,
    parameter int WIN_COUNT  = proj_pkg::FM_RAMS_COUNT * proj_pkg::FM_ENTRIES_COUNT *
                               proj_pkg::FM_OFFSET_COUNT / READ_BYTES,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            in_clk,
    input  logic                            in_rst_n,
    input  logic [READ_BYTES*DATA_BITS-1:0] in_rdata,
    input  logic                            in_rdata_valid,
    output logic [DATA_BITS-1:0]            out_byte,
    output logic                            out_byte_valid,
    input  logic                            in_byte_ready,
    output logic                            out_last,
    output logic [$clog2(WIN_COUNT)-1:0]    out_win_idx,
    output logic                            out_buf_sel,
    output logic                            out_overflow,
    input  logic                            in_clr
`ifdef PROJ_FM_READER_DROP_CNT_EN
    ,
    output logic [15:0]                     out_drop_cnt
`endif
);

    localparam int WIN_W = $clog2(WIN_COUNT);
    localparam int BC_W  = (READ_BYTES > 1) ? $clog2(READ_BYTES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, SEND} state_t;
    typedef logic [READ_BYTES-1:0][DATA_BITS-1:0] win_t;

    win_t             mem_q [FIFO_DEPTH];
    win_t             head;
    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BC_W-1:0]  bcnt_q, bcnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             buf_q, buf_d;
    logic             ovf_q, ovf_d;
    logic             full, last, hs, pop, push, drop;

    assign full = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign last = (bcnt_q == BC_W'(READ_BYTES - 1));
    assign hs   = (state_q == SEND) && in_byte_ready;
    assign pop  = hs && last;
    // A final-byte pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign push = in_rdata_valid && (!full || pop);
    assign drop = in_rdata_valid && full && !pop;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        bcnt_d   = bcnt_q;
        win_d    = win_q;
        buf_d    = buf_q;
        if (hs) begin
            bcnt_d = last ? '0 : bcnt_q + BC_W'(1);
        end
        if (pop) begin
            if (win_q == WIN_W'(WIN_COUNT - 1)) begin
                win_d = '0;
                buf_d = ~buf_q;
            end else begin
                win_d = win_q + WIN_W'(1);
            end
        end
        ovf_d = drop ? 1'b1 : (in_clr ? 1'b0 : ovf_q);
    end

    always_comb begin
        state_d        = state_q;
        out_byte_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (push) state_d = SEND;
            end
            SEND: begin
                out_byte_valid = 1'b1;
                if (cnt_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_byte     = out_byte_valid ? head[bcnt_q] : '0;
    assign out_last     = out_byte_valid && last;
    assign out_win_idx  = win_q;
    assign out_buf_sel  = buf_q;
    assign out_overflow = ovf_q;

    always_ff @(posedge in_clk) begin
        if (push) mem_q[wr_ptr_q] <= in_rdata;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            bcnt_q   <= '0;
            win_q    <= '0;
            buf_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            win_q    <= win_d;
            buf_q    <= buf_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef PROJ_FM_READER_DROP_CNT_EN
    logic [15:0] dcnt_q, dcnt_d;

    always_comb begin
        dcnt_d = in_clr ? '0 : dcnt_q;
        if (drop && (dcnt_d != 16'hFFFF)) dcnt_d = dcnt_d + 16'd1;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) dcnt_q <= '0;
        else           dcnt_q <= dcnt_d;
    end

    assign out_drop_cnt = dcnt_q;
`endif

endmodule

// File: doc/proj_fm_reader.md
PROJ_FM_READER -- requirements
Module: proj_fm_reader

Interface
REQ-001 SHALL have parameter DATA_BITS, default proj_pkg::FM_GENOME_BTYE (8), width of one genome byte.
REQ-002 SHALL have parameter READ_BYTES, default proj_pkg::FM_EXTENDER_BYTES_READ_COUNT (4), number of bytes per FM read window.
REQ-003 SHALL have parameter WIN_COUNT, default FM_RAMS_COUNT*FM_ENTRIES_COUNT*FM_OFFSET_COUNT/READ_BYTES, number of windows per FM buffer.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, number of windows held in the internal window FIFO (power of two, at least 2).
REQ-005 in_clk  input  1  single clock, all logic on its rising edge.
REQ-006 in_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_rdata  input  READ_BYTES*DATA_BITS  FM read window; byte i = bits [(i+1)*DATA_BITS-1 : i*DATA_BITS].
REQ-008 in_rdata_valid  input  1  one-cycle strobe marking in_rdata as a new window; there is no backpressure toward the FM.
REQ-009 out_byte  output  DATA_BITS  current serialized genome byte.
REQ-010 out_byte_valid  output  1  out_byte is valid.
REQ-011 in_byte_ready  input  1  downstream accepts out_byte when high together with out_byte_valid.
REQ-012 out_last  output  1  out_byte is the final byte (byte READ_BYTES-1) of its window.
REQ-013 out_win_idx  output  $clog2(WIN_COUNT)  index of the window currently on out_byte.
REQ-014 out_buf_sel  output  1  ping-pong buffer parity of the current window.
REQ-015 out_overflow  output  1  sticky flag: a window was dropped.
REQ-016 in_clr  input  1  synchronous clear of out_overflow.

Function
REQ-017 A window SHALL be pushed into the FIFO on any cycle with in_rdata_valid high and the FIFO not full.
REQ-018 A window arriving while the FIFO is full and no pop occurs in the same cycle SHALL be dropped and SHALL set out_overflow on the next edge.
REQ-019 A simultaneous push and final-byte pop with the FIFO full SHALL be accepted with no drop.
REQ-020 The FSM SHALL have the states IDLE (FIFO empty, out_byte_valid=0) and SEND (head window being serialized).
REQ-021 IDLE SHALL move to SEND one cycle after a push, so the first byte is valid on the cycle after in_rdata_valid.
REQ-022 In SEND, bytes SHALL be emitted in order 0..READ_BYTES-1 using a byte counter that advances only on a handshake (valid && ready).
REQ-023 out_byte, out_last, out_win_idx and out_buf_sel SHALL remain stable while out_byte_valid=1 and in_byte_ready=0.
REQ-024 The handshake on the last byte SHALL pop the head window; the FSM SHALL stay in SEND with byte 0 of the next window on the following cycle if the FIFO is non-empty, otherwise it SHALL enter IDLE.
REQ-025 The window counter SHALL increment on every pop, wrap from WIN_COUNT-1 to 0, and toggle the buffer-select bit on that wrap; out_win_idx/out_buf_sel SHALL reflect the head window's values.
REQ-026 Dropped windows SHALL NOT advance the window counter.
REQ-027 in_clr SHALL clear out_overflow unless a drop occurs in the same cycle, in which case the flag SHALL be set.

Reset
REQ-028 Asserting in_rst_n low SHALL immediately clear the FIFO, the byte counter, the window counter, buffer select and out_overflow, and SHALL force the FSM to IDLE, even while a window is being serialized.
REQ-029 During reset all outputs SHALL be 0.
REQ-030 The first in_rdata_valid on or after the first edge following deassertion SHALL be accepted.

Configuration
REQ-031 Macro PROJ_FM_READER_DROP_CNT_EN defined: the module SHALL add output out_drop_cnt, 16 bits, counting dropped windows, saturating at 16'hFFFF, cleared by reset and by in_clr.
REQ-032 Macro undefined: the out_drop_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL cover: reset, then window 32'h44332211 strobed with ready held 1 -> out_byte 11,22,33,44 on consecutive cycles starting one cycle after the strobe, out_last only with 44, out_win_idx=0.
REQ-034 The bench SHALL cover: ready toggled 1,0,0,1 mid-window -> out_byte is held unchanged during the stall and no byte is duplicated or lost.
REQ-035 The bench SHALL cover: three windows strobed back-to-back with ready=0 -> the third window is dropped, out_overflow=1 and out_drop_cnt=1 when the macro is defined; after release, exactly 8 bytes are emitted.
REQ-036 The bench SHALL cover: WIN_COUNT+1 windows streamed -> out_win_idx wraps to 0 and out_buf_sel goes 0->1 on window WIN_COUNT.
REQ-037 The bench SHALL cover: in_rst_n asserted while byte 2 is on the output -> out_byte_valid=0 immediately, and the next window starts at byte 0 with out_win_idx=0.
